// File: rtl/ace_snoop_responder.sv
// ace_snoop_responder: cache-side ACE snoop handler. Takes one AC snoop at a time,
// looks up the tag array, answers on CR, streams the line on CD when required,
// then commits the coherence state change.
module ace_snoop_responder #(
  parameter int AddrWidth = 64,
  parameter int DataWidth = 64,
  parameter int LineBytes = 64
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 ac_valid_i,
  output logic                 ac_ready_o,
  input  logic [AddrWidth-1:0] ac_addr_i,
  input  logic [3:0]           ac_snoop_i,
  output logic                 cr_valid_o,
  input  logic                 cr_ready_i,
  output logic [4:0]           cr_resp_o,
  output logic                 cd_valid_o,
  input  logic                 cd_ready_i,
  output logic [DataWidth-1:0] cd_data_o,
  output logic                 cd_last_o,
  output logic                 lu_valid_o,
  input  logic                 lu_ready_i,
  output logic [AddrWidth-1:0] lu_addr_o,
  input  logic                 lu_rsp_valid_i,
  input  logic                 lu_hit_i,
  input  logic                 lu_dirty_i,
  input  logic                 lu_unique_i,
  output logic                 rd_valid_o,
  input  logic                 rd_ready_i,
  output logic [((LineBytes*8/DataWidth) > 1 ? $clog2(LineBytes*8/DataWidth) : 1)-1:0] rd_beat_o,
  input  logic                 rd_rvalid_i,
  input  logic [DataWidth-1:0] rd_rdata_i,
  output logic                 upd_valid_o,
  input  logic                 upd_ready_i,
  output logic                 upd_inval_o
);

  localparam int Beats = LineBytes * 8 / DataWidth;
  localparam int BeatW = (Beats > 1) ? $clog2(Beats) : 1;
  localparam logic [BeatW-1:0]     LastBeat = BeatW'(Beats - 1);
  localparam logic [AddrWidth-1:0] LineMask = ~(AddrWidth'(LineBytes - 1));

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOOKUP  = 3'd1;
  localparam logic [2:0] S_WAIT_LU = 3'd2;
  localparam logic [2:0] S_CR      = 3'd3;
  localparam logic [2:0] S_DATA    = 3'd4;
  localparam logic [2:0] S_UPD     = 3'd5;

  logic [2:0]           state;
  logic [AddrWidth-1:0] addr_q;
  logic [3:0]           snoop_q;
  logic [4:0]           resp_q;
  logic                 upd_need_q, inval_q, ac_rdy_q;
  logic [BeatW-1:0]     rd_beat_q, cd_beat_q;
  logic                 rd_all_q;
  logic [1:0]           inflight_q, cnt_q;
  logic                 wptr_q, rptr_q;
  logic [DataWidth-1:0] mem_q [2];

  logic [4:0] resp_n;
  logic       upd_n, inval_n;
  logic       ac_hs, rd_hs, cd_hs, cd_done;

  assign ac_hs   = ac_valid_i && ac_ready_o;
  assign rd_hs   = rd_valid_o && rd_ready_i;
  assign cd_hs   = cd_valid_o && cd_ready_i;
  assign cd_done = cd_hs && cd_last_o;

  assign ac_ready_o  = ac_rdy_q;
  assign lu_valid_o  = (state == S_LOOKUP);
  assign lu_addr_o   = addr_q & LineMask;
  assign cr_valid_o  = (state == S_CR);
  assign cr_resp_o   = resp_q;
  assign upd_valid_o = (state == S_UPD);
  assign upd_inval_o = inval_q;
  assign rd_beat_o   = rd_beat_q;
  // Two-credit rule: outstanding reads plus buffered beats never exceed the FIFO depth.
  assign rd_valid_o  = (state == S_DATA) && !rd_all_q && (({1'b0, inflight_q} + {1'b0, cnt_q}) < 3'd2);
  assign cd_valid_o  = (cnt_q != 2'd0);
  assign cd_data_o   = mem_q[rptr_q];
  assign cd_last_o   = cd_valid_o && (cd_beat_q == LastBeat);

  // CR bits {WasUnique,IsShared,PassDirty,Error,DataTransfer} and follow-up state change.
  always_comb begin
    resp_n  = 5'b00000;
    upd_n   = 1'b0;
    inval_n = 1'b0;
    case (snoop_q)
      4'b0000: if (lu_hit_i) resp_n = {lu_unique_i, 1'b1, 1'b0, 1'b0, 1'b1};
      4'b0001, 4'b0010, 4'b0011: if (lu_hit_i) begin
        resp_n = {lu_unique_i, 1'b1, lu_dirty_i, 1'b0, 1'b1};
        upd_n  = 1'b1;
      end
      4'b0111: if (lu_hit_i) begin
        resp_n  = {lu_unique_i, 1'b0, lu_dirty_i, 1'b0, 1'b1};
        upd_n   = 1'b1;
        inval_n = 1'b1;
      end
      4'b1000: if (lu_hit_i) begin
        resp_n = {lu_unique_i, 1'b1, lu_dirty_i, 1'b0, lu_dirty_i};
        upd_n  = lu_dirty_i;
      end
      4'b1001: if (lu_hit_i) begin
        resp_n  = {lu_unique_i, 1'b0, lu_dirty_i, 1'b0, lu_dirty_i};
        upd_n   = 1'b1;
        inval_n = 1'b1;
      end
      4'b1101: if (lu_hit_i) begin
        resp_n  = {lu_unique_i, 4'b0000};
        upd_n   = 1'b1;
        inval_n = 1'b1;
      end
      default: resp_n = 5'b00010;
    endcase
  end

  // Snoop sequencing; ac_ready lags entry into IDLE by one cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= S_IDLE;
      ac_rdy_q   <= 1'b0;
      addr_q     <= '0;
      snoop_q    <= 4'b0000;
      resp_q     <= 5'b00000;
      upd_need_q <= 1'b0;
      inval_q    <= 1'b0;
    end else begin
      ac_rdy_q <= (state == S_IDLE) && !ac_hs;
      case (state)
        S_IDLE: if (ac_hs) begin
          addr_q  <= ac_addr_i;
          snoop_q <= ac_snoop_i;
          state   <= S_LOOKUP;
        end
        S_LOOKUP:  if (lu_ready_i) state <= S_WAIT_LU;
        S_WAIT_LU: if (lu_rsp_valid_i) begin
          resp_q     <= resp_n;
          upd_need_q <= upd_n;
          inval_q    <= inval_n;
          state      <= S_CR;
        end
        S_CR: if (cr_ready_i) begin
          if (resp_q[0])       state <= S_DATA;
          else if (upd_need_q) state <= S_UPD;
          else                 state <= S_IDLE;
        end
        S_DATA: if (cd_done) state <= upd_need_q ? S_UPD : S_IDLE;
        S_UPD:  if (upd_ready_i) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Read issue, credit tracking and CD beat counting.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_beat_q  <= '0;
      rd_all_q   <= 1'b0;
      cd_beat_q  <= '0;
      inflight_q <= 2'd0;
      cnt_q      <= 2'd0;
      wptr_q     <= 1'b0;
      rptr_q     <= 1'b0;
    end else begin
      if (rd_hs) begin
        rd_beat_q <= (rd_beat_q == LastBeat) ? '0 : rd_beat_q + 1'b1;
        if (rd_beat_q == LastBeat) rd_all_q <= 1'b1;
      end
      if (cd_done) rd_all_q <= 1'b0;
      case ({rd_hs, rd_rvalid_i})
        2'b10:   inflight_q <= inflight_q + 2'd1;
        2'b01:   inflight_q <= inflight_q - 2'd1;
        default: ;
      endcase
      if (rd_rvalid_i) wptr_q <= ~wptr_q;
      if (cd_hs) begin
        rptr_q    <= ~rptr_q;
        cd_beat_q <= (cd_beat_q == LastBeat) ? '0 : cd_beat_q + 1'b1;
      end
      case ({rd_rvalid_i, cd_hs})
        2'b10:   cnt_q <= cnt_q + 2'd1;
        2'b01:   cnt_q <= cnt_q - 2'd1;
        default: ;
      endcase
    end
  end

  // FIFO storage; contents are don't-care while empty, so no reset.
  always_ff @(posedge clk_i) begin
    if (rd_rvalid_i) mem_q[wptr_q] <= rd_rdata_i;
  end

endmodule

// File: tb/tb_ace_snoop_responder.sv
// tb_ace_snoop_responder: directed snoops against a small cache-side model
// (lookup responder, in-order read data pipe) with a CD scoreboard.
module tb_ace_snoop_responder;
  localparam int NB = 8;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        ac_valid_i = 1'b0, ac_ready_o;
  logic [63:0] ac_addr_i = '0;
  logic [3:0]  ac_snoop_i = '0;
  logic        cr_valid_o, cr_ready_i = 1'b1;
  logic [4:0]  cr_resp_o;
  logic        cd_valid_o, cd_ready_i = 1'b1, cd_last_o;
  logic [63:0] cd_data_o;
  logic        lu_valid_o, lu_ready_i = 1'b1;
  logic [63:0] lu_addr_o;
  logic        lu_rsp_valid_i = 1'b0, lu_hit_i = 1'b0, lu_dirty_i = 1'b0, lu_unique_i = 1'b0;
  logic        rd_valid_o, rd_ready_i = 1'b1;
  logic [2:0]  rd_beat_o;
  logic        rd_rvalid_i = 1'b0;
  logic [63:0] rd_rdata_i = '0;
  logic        upd_valid_o, upd_ready_i = 1'b1, upd_inval_o;

  always #5 clk = ~clk;

  ace_snoop_responder dut (
    .clk_i(clk), .rst_i(rst_i),
    .ac_valid_i(ac_valid_i), .ac_ready_o(ac_ready_o), .ac_addr_i(ac_addr_i), .ac_snoop_i(ac_snoop_i),
    .cr_valid_o(cr_valid_o), .cr_ready_i(cr_ready_i), .cr_resp_o(cr_resp_o),
    .cd_valid_o(cd_valid_o), .cd_ready_i(cd_ready_i), .cd_data_o(cd_data_o), .cd_last_o(cd_last_o),
    .lu_valid_o(lu_valid_o), .lu_ready_i(lu_ready_i), .lu_addr_o(lu_addr_o),
    .lu_rsp_valid_i(lu_rsp_valid_i), .lu_hit_i(lu_hit_i), .lu_dirty_i(lu_dirty_i), .lu_unique_i(lu_unique_i),
    .rd_valid_o(rd_valid_o), .rd_ready_i(rd_ready_i), .rd_beat_o(rd_beat_o),
    .rd_rvalid_i(rd_rvalid_i), .rd_rdata_i(rd_rdata_i),
    .upd_valid_o(upd_valid_o), .upd_ready_i(upd_ready_i), .upd_inval_o(upd_inval_o)
  );

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] beat_data(input logic [63:0] a, input int b);
    return {a[31:0] ^ 32'hA5A5_0000, 24'h0, 8'(b)};
  endfunction

  // cache-side model state
  int          cyc = 0, rd_lat = 1;
  int          rd_seen = 0, cd_seen = 0, upd_seen = 0, rd_base = 0, cd_base = 0;
  int          inflight = 0, max_inflight = 0;
  logic        upd_inval_seen = 1'b0, cd_tog = 1'b0;
  logic [63:0] cur_addr = '0;
  int          q_beat[$], q_due[$];

  // Observe handshakes mid-cycle, then drive the cache-side inputs just after the edge.
  always begin
    logic rst_seen, lu_hs_s, rd_hs_s, stall_prev;
    logic [63:0] stall_data;
    int rd_hs_beat, idx;
    stall_prev = 1'b0;
    stall_data = '0;
    forever begin
      @(negedge clk);
      rst_seen = rst_i;
      lu_hs_s  = 1'b0;
      rd_hs_s  = 1'b0;
      if (!rst_i) begin
        lu_hs_s = lu_valid_o && lu_ready_i;
        if (rd_valid_o && rd_ready_i) begin
          chk("rd_beat_order", 64'(rd_beat_o), 64'((rd_seen - rd_base) % NB));
          rd_hs_s = 1'b1;
          rd_hs_beat = int'(rd_beat_o);
          rd_seen++;
          inflight++;
          chk("rd_credit", 64'(inflight <= 2), 64'(1));
          if (inflight > max_inflight) max_inflight = inflight;
        end
        if (rd_rvalid_i) inflight--;
        if (stall_prev) begin
          chk("cd_hold_valid", 64'(cd_valid_o), 64'(1));
          chk("cd_hold_data", cd_data_o, stall_data);
        end
        stall_prev = cd_valid_o && !cd_ready_i;
        stall_data = cd_data_o;
        if (cd_valid_o && cd_ready_i) begin
          idx = (cd_seen - cd_base) % NB;
          chk("cd_data", cd_data_o, beat_data(cur_addr, idx));
          chk("cd_last", 64'(cd_last_o), 64'(idx == NB - 1));
          cd_seen++;
        end
        if (upd_valid_o && upd_ready_i) begin
          upd_seen++;
          upd_inval_seen = upd_inval_o;
        end
      end else begin
        stall_prev = 1'b0;
      end
      @(posedge clk);
      #1;
      cyc++;
      rd_rvalid_i = 1'b0;
      if (rst_seen) begin
        q_beat.delete();
        q_due.delete();
        inflight = 0;
        lu_rsp_valid_i = 1'b0;
      end else begin
        lu_rsp_valid_i = lu_hs_s;
        if (rd_hs_s) begin
          q_beat.push_back(rd_hs_beat);
          q_due.push_back(cyc - 1 + rd_lat);
        end
        if (q_due.size() > 0 && q_due[0] == cyc) begin
          rd_rvalid_i = 1'b1;
          rd_rdata_i  = beat_data(cur_addr, q_beat[0]);
          void'(q_beat.pop_front());
          void'(q_due.pop_front());
        end
      end
      cd_ready_i = cd_tog ? ~cd_ready_i : 1'b1;
    end
  end

  task automatic start_ac(input logic [63:0] a, input logic [3:0] op, input logic h, d, u,
                          input int lat, input logic tog, input logic crr);
    @(posedge clk);
    #2;
    cur_addr = a; rd_base = rd_seen; cd_base = cd_seen;
    lu_hit_i = h; lu_dirty_i = d; lu_unique_i = u;
    rd_lat = lat; cd_tog = tog; cr_ready_i = crr;
    ac_valid_i = 1'b1; ac_addr_i = a; ac_snoop_i = op;
  endtask

  task automatic snoop(input string nm, input logic [63:0] a, input logic [3:0] op,
                       input logic h, d, u, input int lat, input logic tog, input int bp,
                       input logic [4:0] er, input int eb, input int eu, input logic ei);
    int k, t0, b0, u0;
    b0 = cd_seen;
    u0 = upd_seen;
    start_ac(a, op, h, d, u, lat, tog, bp == 0);
    k = 0;
    @(negedge clk);
    while (!ac_ready_o && k < 50) begin k++; @(negedge clk); end
    chk({nm, " ac_accept"}, 64'(ac_ready_o), 64'(1));
    t0 = cyc;
    @(posedge clk);
    #2;
    ac_valid_i = 1'b0;
    k = 0;
    @(negedge clk);
    while (!lu_valid_o && k < 50) begin k++; @(negedge clk); end
    chk({nm, " lu_valid"}, 64'(lu_valid_o), 64'(1));
    chk({nm, " lu_addr"}, lu_addr_o, a & ~64'h3F);
    k = 0;
    while (!cr_valid_o && k < 50) begin k++; @(negedge clk); end
    chk({nm, " cr_valid"}, 64'(cr_valid_o), 64'(1));
    chk({nm, " cr_latency"}, 64'(cyc - t0), 64'(3));
    chk({nm, " cr_resp"}, 64'(cr_resp_o), 64'(er));
    for (int i = 0; i < bp; i++) begin
      @(negedge clk);
      chk({nm, " bp_cr_valid"}, 64'(cr_valid_o), 64'(1));
      chk({nm, " bp_cr_resp"}, 64'(cr_resp_o), 64'(er));
      chk({nm, " bp_ac_ready"}, 64'(ac_ready_o), 64'(0));
    end
    if (bp > 0) begin
      @(posedge clk);
      #2;
      cr_ready_i = 1'b1;
    end
    k = 0;
    @(negedge clk);
    while (!ac_ready_o && k < 400) begin k++; @(negedge clk); end
    chk({nm, " done"}, 64'(ac_ready_o), 64'(1));
    chk({nm, " cd_beats"}, 64'(cd_seen - b0), 64'(eb));
    chk({nm, " upd_count"}, 64'(upd_seen - u0), 64'(eu));
    if (eu > 0) chk({nm, " upd_inval"}, 64'(upd_inval_seen), 64'(ei));
    cd_tog = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    repeat (3) @(negedge clk);
    chk("rst ac_ready", 64'(ac_ready_o), 64'(0));
    chk("rst valids", 64'({cr_valid_o, cd_valid_o, lu_valid_o, rd_valid_o, upd_valid_o}), 64'(0));
    @(posedge clk);
    #2;
    rst_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle ac_ready", 64'(ac_ready_o), 64'(1));

    //     name        addr          op       h     d     u    lat tog  bp  resp      beats upd inval
    snoop("miss",     64'h1040, 4'b0001, 1'b0, 1'b0, 1'b0, 1, 1'b0, 0, 5'b00000, 0, 0, 1'b0);
    snoop("ru",       64'h2000, 4'b0111, 1'b1, 1'b1, 1'b1, 1, 1'b1, 0, 5'b10101, 8, 1, 1'b1);
    snoop("rs",       64'h3085, 4'b0001, 1'b1, 1'b0, 1'b0, 3, 1'b0, 0, 5'b01001, 8, 1, 1'b0);
    snoop("cs_clean", 64'h40C0, 4'b1000, 1'b1, 1'b0, 1'b0, 1, 1'b0, 0, 5'b01000, 0, 0, 1'b0);
    snoop("err",      64'h5000, 4'b0101, 1'b1, 1'b1, 1'b1, 1, 1'b0, 0, 5'b00010, 0, 0, 1'b0);
    snoop("ci_bp",    64'h6100, 4'b1001, 1'b1, 1'b1, 1'b1, 2, 1'b0, 10, 5'b10101, 8, 1, 1'b1);
    snoop("mi",       64'h7000, 4'b1101, 1'b1, 1'b0, 1'b1, 1, 1'b0, 0, 5'b10000, 0, 1, 1'b1);
    snoop("ro",       64'h8000, 4'b0000, 1'b1, 1'b1, 1'b1, 1, 1'b1, 0, 5'b11001, 8, 0, 1'b0);
    snoop("cs_dirty", 64'h9040, 4'b1000, 1'b1, 1'b1, 1'b0, 2, 1'b0, 0, 5'b01101, 8, 1, 1'b0);
    chk("max_inflight", 64'(max_inflight), 64'(2));

    // reset in the middle of the CD burst
    start_ac(64'hA000, 4'b0111, 1'b1, 1'b1, 1'b1, 2, 1'b0, 1'b1);
    k = 0;
    @(negedge clk);
    while (!ac_ready_o && k < 50) begin k++; @(negedge clk); end
    @(posedge clk);
    #2;
    ac_valid_i = 1'b0;
    k = 0;
    @(negedge clk);
    while ((cd_seen - cd_base) < 3 && k < 200) begin k++; @(negedge clk); end
    chk("rst_mid beats_reached", 64'((cd_seen - cd_base) >= 3), 64'(1));
    @(posedge clk);
    #2;
    rst_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_mid valids", 64'({cr_valid_o, cd_valid_o, lu_valid_o, rd_valid_o, upd_valid_o}), 64'(0));
    chk("rst_mid ac_ready", 64'(ac_ready_o), 64'(0));
    @(posedge clk);
    #2;
    rst_i = 1'b0;
    snoop("post_rst", 64'hB040, 4'b0111, 1'b1, 1'b1, 1'b1, 1, 1'b0, 0, 5'b10101, 8, 1, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
